// File: rtl/i2c_target_regfile.sv
// ============================================================================
//  Module      : i2c_target_regfile
//  Description : I2C target (slave) with a 128x8 register file, auto-
//                incrementing register pointer and a local update port.
//                Optional input glitch filter: I2C_TGT_GLITCH_FILTER_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_target_regfile #(
  parameter logic [6:0] DEV_ADDR   = 7'h68,
  parameter logic [7:0] WHOAMI_VAL = 8'h68
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  input  logic       upd_en,
  input  logic [6:0] upd_addr,
  input  logic [7:0] upd_data,
  output logic       wr_stb,
  output logic [6:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ADDR     = 4'd1,
    ST_ADDR_ACK = 4'd2,
    ST_PTR      = 4'd3,
    ST_PTR_ACK  = 4'd4,
    ST_WR_DATA  = 4'd5,
    ST_WR_ACK   = 4'd6,
    ST_RD_DATA  = 4'd7,
    ST_RD_ACK   = 4'd8
  } state_t;

  // --------------------------------------------------------------------------
  // Input synchronizers and edge detection
  // --------------------------------------------------------------------------
  logic scl_s1_q, scl_s1_d, scl_s2_q, scl_s2_d;
  logic sda_s1_q, sda_s1_d, sda_s2_q, sda_s2_d;
  logic scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
  logic scl_sync, sda_sync;

  // Next values of the two-flop synchronizers and the edge-history flops
  always_comb begin
    scl_s1_d   = scl_i;
    scl_s2_d   = scl_s1_q;
    sda_s1_d   = sda_i;
    sda_s2_d   = sda_s1_q;
    scl_prev_d = scl_sync;
    sda_prev_d = sda_sync;
  end

  // Synchronizer and edge-history registers; idle-bus level is high
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      scl_s1_q   <= 1'b1;
      scl_s2_q   <= 1'b1;
      sda_s1_q   <= 1'b1;
      sda_s2_q   <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_s1_q   <= scl_s1_d;
      scl_s2_q   <= scl_s2_d;
      sda_s1_q   <= sda_s1_d;
      sda_s2_q   <= sda_s2_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
    end
  end

`ifdef I2C_TGT_GLITCH_FILTER_EN
  logic       scl_f_q, scl_f_d, sda_f_q, sda_f_d;
  logic [1:0] scl_fc_q, scl_fc_d, sda_fc_q, sda_fc_d;

  // Filtered level follows the synchronized input only after 4 equal samples
  always_comb begin
    scl_f_d  = scl_f_q;
    scl_fc_d = 2'd0;
    sda_f_d  = sda_f_q;
    sda_fc_d = 2'd0;
    if (scl_s2_q != scl_f_q) begin
      if (scl_fc_q == 2'd3) scl_f_d  = scl_s2_q;
      else                  scl_fc_d = scl_fc_q + 2'd1;
    end
    if (sda_s2_q != sda_f_q) begin
      if (sda_fc_q == 2'd3) sda_f_d  = sda_s2_q;
      else                  sda_fc_d = sda_fc_q + 2'd1;
    end
  end

  // Filter state registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      scl_f_q  <= 1'b1;
      sda_f_q  <= 1'b1;
      scl_fc_q <= 2'd0;
      sda_fc_q <= 2'd0;
    end else begin
      scl_f_q  <= scl_f_d;
      sda_f_q  <= sda_f_d;
      scl_fc_q <= scl_fc_d;
      sda_fc_q <= sda_fc_d;
    end
  end

  assign scl_sync = scl_f_q;
  assign sda_sync = sda_f_q;
`else
  assign scl_sync = scl_s2_q;
  assign sda_sync = sda_s2_q;
`endif

  logic scl_rise, scl_fall, start_evt, stop_evt;
  assign scl_rise  =  scl_sync & ~scl_prev_q;
  assign scl_fall  = ~scl_sync &  scl_prev_q;
  assign start_evt =  scl_sync &  scl_prev_q &  sda_prev_q & ~sda_sync;
  assign stop_evt  =  scl_sync &  scl_prev_q & ~sda_prev_q &  sda_sync;

  // --------------------------------------------------------------------------
  // Protocol FSM
  // --------------------------------------------------------------------------
  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;        // SCL rises seen in the current byte
  logic [7:0] sh_q, sh_d;          // receive / transmit shift register
  logic [6:0] ptr_q, ptr_d;
  logic       rw_q, rw_d;
  logic       sda_oe_q, sda_oe_d;
  logic       wr_stb_q, wr_stb_d;
  logic [6:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       bus_wr;
  logic [7:0] rd_byte;
  logic [7:0] regs_q [0:127];
  logic [7:0] regs_d [0:127];

  assign rd_byte = regs_q[ptr_q];

  // Next-state and output logic; STOP outranks START, both outrank bit events
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    sda_oe_d  = sda_oe_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    bus_wr    = 1'b0;
    if (stop_evt) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
    end else if (start_evt) begin
      state_d  = ST_ADDR;
      cnt_d    = 4'd0;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_PTR, ST_WR_DATA: begin
          if (scl_rise) begin
            sh_d  = {sh_q[6:0], sda_sync};
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            cnt_d = 4'd0;
            if (state_q == ST_ADDR) begin
              if (sh_q[7:1] == DEV_ADDR) begin
                state_d  = ST_ADDR_ACK;
                sda_oe_d = 1'b1;
                rw_d     = sh_q[0];
              end else begin
                state_d  = ST_IDLE;
              end
            end else if (state_q == ST_PTR) begin
              state_d  = ST_PTR_ACK;
              ptr_d    = sh_q[6:0];
              sda_oe_d = 1'b1;
            end else begin
              state_d   = ST_WR_ACK;
              sda_oe_d  = 1'b1;
              bus_wr    = 1'b1;
              wr_stb_d  = 1'b1;
              wr_addr_d = ptr_q;
              wr_data_d = sh_q;
              ptr_d     = ptr_q + 7'd1;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            cnt_d = 4'd0;
            if (rw_q) begin
              state_d  = ST_RD_DATA;
              sh_d     = rd_byte;
              sda_oe_d = ~rd_byte[7];
              ptr_d    = ptr_q + 7'd1;
            end else begin
              state_d  = ST_PTR;
              sda_oe_d = 1'b0;
            end
          end
        end
        ST_PTR_ACK, ST_WR_ACK: begin
          if (scl_fall) begin
            state_d  = ST_WR_DATA;
            cnt_d    = 4'd0;
            sda_oe_d = 1'b0;
          end
        end
        ST_RD_DATA: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              state_d  = ST_RD_ACK;
              cnt_d    = 4'd0;
              sda_oe_d = 1'b0;
            end else if (cnt_q != 4'd0) begin
              sh_d     = {sh_q[6:0], 1'b0};
              sda_oe_d = ~sh_q[6];
            end
          end
        end
        ST_RD_ACK: begin
          // Master NACK ends the read; ACK streams the next register
          if (scl_rise && sda_sync) begin
            state_d = ST_IDLE;
          end else if (scl_fall) begin
            state_d  = ST_RD_DATA;
            cnt_d    = 4'd0;
            sh_d     = rd_byte;
            sda_oe_d = ~rd_byte[7];
            ptr_d    = ptr_q + 7'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // FSM and datapath registers; reset releases SDA asynchronously
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      sh_q      <= 8'h00;
      ptr_q     <= 7'd0;
      rw_q      <= 1'b0;
      sda_oe_q  <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= 7'd0;
      wr_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      ptr_q     <= ptr_d;
      rw_q      <= rw_d;
      sda_oe_q  <= sda_oe_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // --------------------------------------------------------------------------
  // Register file: local update is applied last so it wins an address clash
  // --------------------------------------------------------------------------
  always_comb begin
    regs_d = regs_q;
    if (bus_wr) regs_d[ptr_q] = sh_q;
    if (upd_en) regs_d[upd_addr] = upd_data;
  end

  // Register array storage with WHOAMI reset value at 0x75
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 128; i++) begin
        regs_q[i] <= (i == 'h75) ? WHOAMI_VAL : 8'h00;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign sda_oe  = sda_oe_q;
  assign wr_stb  = wr_stb_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_i2c_target_regfile.sv
// ============================================================================
//  Module      : tb_i2c_target_regfile
//  Description : Directed self-checking bench for i2c_target_regfile; acts as
//                the I2C bus master on an open-drain SDA model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2c_target_regfile;

  localparam int Q = 10;  // quarter SCL period in clk cycles

  logic       clk;
  logic       resetn;
  logic       scl;
  logic       sda_m;
  logic       upd_en;
  logic [6:0] upd_addr;
  logic [7:0] upd_data;
  wire        sda_oe;
  wire        wr_stb;
  wire  [6:0] wr_addr;
  wire  [7:0] wr_data;
  wire        busy;
  wire        sda_bus;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_target_regfile dut (
    .clk      (clk),
    .resetn   (resetn),
    .scl_i    (scl),
    .sda_i    (sda_bus),
    .sda_oe   (sda_oe),
    .upd_en   (upd_en),
    .upd_addr (upd_addr),
    .upd_data (upd_data),
    .wr_stb   (wr_stb),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int stb_cnt  = 0;
  int oe_cnt   = 0;
  logic [6:0] log_addr [0:15];
  logic [7:0] log_data [0:15];

  // Log every write strobe and count cycles with SDA pulled low
  always @(negedge clk) begin
    if (wr_stb) begin
      log_addr[stb_cnt % 16] = wr_addr;
      log_data[stb_cnt % 16] = wr_data;
      stb_cnt = stb_cnt + 1;
    end
    if (sda_oe) oe_cnt = oe_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wq(input int n);
    repeat (n * Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wq(1);
    scl   = 1'b1; wq(1);
    sda_m = 1'b0; wq(1);
    scl   = 1'b0;
  endtask

  task automatic i2c_stop();
    wq(1); sda_m = 1'b0;
    wq(1); scl   = 1'b1;
    wq(1); sda_m = 1'b1;
    wq(1);
  endtask

  task automatic wb(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      wq(1); sda_m = d[i];
      wq(1); scl = 1'b1;
      wq(2); scl = 1'b0;
    end
    wq(1); sda_m = 1'b1;
    wq(1); scl = 1'b1;
    wq(1); ack = ~sda_bus;
    wq(1); scl = 1'b0;
  endtask

  task automatic rb(output logic [7:0] d, input logic mack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1;
      wq(2); scl = 1'b1;
      wq(1); d[i] = sda_bus;
      wq(1); scl = 1'b0;
    end
    wq(1); sda_m = ~mack;
    wq(1); scl = 1'b1;
    wq(2); scl = 1'b0;
  endtask

  // START, write address, pointer, repeated START, read address
  task automatic rd_setup(input logic [7:0] p, output logic [2:0] acks);
    i2c_start();
    wb(8'hD0, acks[2]);
    wb(p,     acks[1]);
    i2c_start();
    wb(8'hD1, acks[0]);
  endtask

  initial begin
    logic [7:0] d;
    logic [2:0] acks;
    logic [3:0] wacks;
    logic       a;
    logic       got;
    int         base;
    int         oe_base;

    scl = 1'b1; sda_m = 1'b1; resetn = 1'b0;
    upd_en = 1'b0; upd_addr = 7'd0; upd_data = 8'h00;
    repeat (5) @(negedge clk);
    chk("rst_sda_oe",  sda_oe,  0);
    chk("rst_wr_stb",  wr_stb,  0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy",    busy,    0);
    resetn = 1'b1;
    wq(1);

    // WHOAMI read through a repeated START
    rd_setup(8'h75, acks);
    chk("whoami_acks", acks, 3'b111);
    chk("whoami_busy", busy, 1);
    rb(d, 1'b0);
    chk("whoami_data", d, 8'h68);
    i2c_stop();
    chk("whoami_busy_after_stop", busy, 0);

    // Two-byte burst write from 0x3B, then read back
    base = stb_cnt;
    i2c_start();
    wb(8'hD0, wacks[3]); wb(8'h3B, wacks[2]); wb(8'h12, wacks[1]); wb(8'h34, wacks[0]);
    i2c_stop();
    chk("burst_acks",   wacks, 4'hF);
    chk("burst_nstb",   stb_cnt - base, 2);
    chk("burst_addr0",  log_addr[base % 16], 7'h3B);
    chk("burst_data0",  log_data[base % 16], 8'h12);
    chk("burst_addr1",  log_addr[(base + 1) % 16], 7'h3C);
    chk("burst_data1",  log_data[(base + 1) % 16], 8'h34);
    rd_setup(8'h3B, acks);
    rb(d, 1'b1); chk("burst_rd0", d, 8'h12);
    rb(d, 1'b0); chk("burst_rd1", d, 8'h34);
    i2c_stop();

    // Wrong device address is ignored
    base = stb_cnt; oe_base = oe_cnt;
    i2c_start();
    wb(8'hA0, a);
    chk("wrong_addr_ack",  a, 0);
    chk("wrong_addr_busy", busy, 0);
    wb(8'h00, a);
    i2c_stop();
    chk("wrong_addr_oe",   oe_cnt - oe_base, 0);
    chk("wrong_addr_nstb", stb_cnt - base, 0);

    // Pointer wrap 0x7F -> 0x00
    base = stb_cnt;
    i2c_start();
    wb(8'hD0, a); wb(8'h7F, a); wb(8'hAA, a); wb(8'hBB, a);
    i2c_stop();
    chk("wrap_addr0", log_addr[base % 16], 7'h7F);
    chk("wrap_data0", log_data[base % 16], 8'hAA);
    chk("wrap_addr1", log_addr[(base + 1) % 16], 7'h00);
    chk("wrap_data1", log_data[(base + 1) % 16], 8'hBB);
    rd_setup(8'h7F, acks);
    rb(d, 1'b1); chk("wrap_rd7f", d, 8'hAA);
    rb(d, 1'b0); chk("wrap_rd00", d, 8'hBB);
    i2c_stop();

    // Local update collides with bus write to 0x10; local data wins
    base = stb_cnt;
    i2c_start();
    wb(8'hD0, a); wb(8'h10, a);
    upd_addr = 7'h10; upd_data = 8'h55; upd_en = 1'b1;
    got = 1'b0;
    fork
      wb(8'h99, a);
      begin
        for (int i = 0; i < 2000; i++) begin
          @(negedge clk);
          if (wr_stb) begin
            got = 1'b1;
            break;
          end
        end
        upd_en = 1'b0;
      end
    join
    i2c_stop();
    chk("clash_stb_seen", got, 1);
    chk("clash_wr_addr",  log_addr[base % 16], 7'h10);
    chk("clash_wr_data",  log_data[base % 16], 8'h99);
    rd_setup(8'h10, acks);
    rb(d, 1'b0); chk("clash_reg", d, 8'h55);
    i2c_stop();

    // Reset in the middle of a read bit while SDA is being pulled low
    i2c_start();
    wb(8'hD0, a); wb(8'h75, a); wb(8'h00, a);
    i2c_stop();
    rd_setup(8'h75, acks);
    for (int i = 0; i < 3; i++) begin
      sda_m = 1'b1;
      wq(2); scl = 1'b1;
      wq(2); scl = 1'b0;
    end
    sda_m = 1'b1;
    wq(2); scl = 1'b1;
    wq(1);
    chk("midrd_oe_before", sda_oe, 1);
    resetn = 1'b0;
    #1;
    chk("midrd_oe_async", sda_oe, 0);
    chk("midrd_busy",     busy,   0);
    @(negedge clk);
    wq(1);
    resetn = 1'b1;
    wq(2);
    rd_setup(8'h75, acks);
    chk("post_rst_acks", acks, 3'b111);
    rb(d, 1'b0);
    chk("post_rst_whoami", d, 8'h68);
    i2c_stop();
    chk("post_rst_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/i2c_target_regfile.md
I2C_TARGET_REGFILE -- requirements
Module: i2c_target_regfile

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports are listed clock and reset first.
REQ-002 Parameter DEV_ADDR, default 7'h68: 7-bit I2C target address that the block answers.
REQ-003 Parameter WHOAMI_VAL, default 8'h68: reset value of register 0x75.
REQ-004 Port clk, input, 1: system clock, 100 MHz nominal; SCL SHALL be at most clk/20.
REQ-005 Port resetn, input, 1: asynchronous active-low reset.
REQ-006 Port scl_i, input, 1: I2C SCL as sampled from the pad.
REQ-007 Port sda_i, input, 1: I2C SDA as sampled from the pad.
REQ-008 Port sda_oe, output, 1: 1 pulls SDA low (open-drain); 0 releases SDA.
REQ-009 Port upd_en, input, 1: local register-update strobe.
REQ-010 Port upd_addr, input, 7: local update register address.
REQ-011 Port upd_data, input, 8: local update data.
REQ-012 Port wr_stb, output, 1: one-cycle pulse when the bus master writes a register.
REQ-013 Port wr_addr, output, 7: register address of the last bus write.
REQ-014 Port wr_data, output, 8: data of the last bus write.
REQ-015 Port busy, output, 1: high from an addressed START through the end of the transaction.

Function
REQ-016 scl_i and sda_i SHALL pass through 2-flop synchronizers; SCL rise and fall events SHALL be detected from the synchronized values.
REQ-017 START (SDA falls while SCL high) SHALL enter ADDR from any state; this includes a repeated START.
REQ-018 STOP (SDA rises while SCL high) SHALL enter IDLE from any state and release sda_oe within 1 clk.
REQ-019 States are IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA and RD_ACK.
REQ-020 Data bits SHALL be sampled on SCL rise, MSB first.
REQ-021 sda_oe SHALL change only within 2 clk after an SCL fall.
REQ-022 In ADDR, after 8 bits:
- if addr[7:1]==DEV_ADDR, the block SHALL ACK by driving sda_oe=1 from the following SCL fall until the next SCL fall;
- otherwise it SHALL enter IDLE, leave sda_oe=0, and ignore the bus until the next START.
REQ-023 Address match with R/W=0 SHALL go ADDR_ACK -> PTR; the received byte loads the 7-bit register pointer (bit 7 ignored) and is ACKed; the block then goes to WR_DATA.
REQ-024 Each WR_DATA byte SHALL be ACKed and written to regs[ptr]; wr_stb pulses for 1 clk with wr_addr=ptr and wr_data=byte, and ptr then increments.
REQ-025 Address match with R/W=1 SHALL, at the SCL fall ending ACK, load regs[ptr] into the shift register and drive its MSB (sda_oe = ~bit); ptr then increments.
REQ-026 In RD_ACK, the master ACK (SDA=0) SHALL load the next byte; a master NACK SHALL enter IDLE with sda_oe=0.
REQ-027 The pointer SHALL wrap from 0x7F to 0x00.
REQ-028 The register file is 128x8 and every register is writable.
REQ-029 If a local update and a bus write target the same address in the same clk, upd_data SHALL win; wr_stb still pulses.
REQ-030 A local update SHALL be visible to any read byte loaded at least 1 clk later.
REQ-031 busy SHALL be 1 in every state except IDLE.

Reset
REQ-032 While resetn=0: state=IDLE, sda_oe=0, wr_stb=0, wr_addr=0, wr_data=0, busy=0, ptr=0, synchronizer flops=1.
REQ-033 While resetn=0, regs SHALL be 0x00 except regs[0x75]=WHOAMI_VAL.
REQ-034 Reset asserted mid-transaction SHALL release SDA immediately (asynchronously); after deassertion the block waits for a START.

Configuration
REQ-035 With I2C_TGT_GLITCH_FILTER_EN defined, the synchronized SCL and SDA SHALL each change only after 4 consecutive equal samples; this adds 3 clk of latency to all event timing (REQ-021 bound becomes 5 clk).
REQ-036 With I2C_TGT_GLITCH_FILTER_EN undefined, no filter SHALL be present and pulses of 1 clk or more SHALL be seen as edges.

Verification
REQ-037 START, 0xD0, 0x75, repeated START, 0xD1, read 1 byte, NACK, STOP -> ACKs on all 3 address/pointer bytes; read data = 0x68; busy=0 after STOP.
REQ-038 START, 0xD0, 0x3B, 0x12, 0x34, STOP -> two wr_stb pulses, (0x3B,0x12) then (0x3C,0x34); a subsequent read from 0x3B returns 0x12, 0x34.
REQ-039 START, 0xA0 (wrong address), 0x00, STOP -> sda_oe stays 0 throughout; no wr_stb pulse.
REQ-040 Pointer 0x7F, write 0xAA, 0xBB -> regs[0x7F]=0xAA and regs[0x00]=0xBB.
REQ-041 upd_en with addr 0x10 and data 0x55 in the same clk as a bus write of 0x99 to 0x10 -> regs[0x10]=0x55 and wr_data=0x99.
REQ-042 resetn pulled low during the 4th data bit of a read -> sda_oe=0 at once; 0x75 reads 0x68 again after the next addressed START.
